// File: rtl/paint_canvas_ctrl.sv
// Paint canvas controller: scans a cell-grid frame buffer out as VGA with a cursor
// overlay, and paints square brushes or clears the canvas through one write port.
module paint_canvas_ctrl #(
    parameter int unsigned PIX_DIV   = 4,
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter int unsigned CELL_LOG2 = 4,
    parameter int unsigned MOVE_DIV  = 2_000_000,
    parameter logic [2:0]  BG_COLOR  = 3'b111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       left,
    input  logic       right,
    input  logic       up,
    input  logic       down,
    input  logic       paint,
    input  logic       clear,
    input  logic [1:0] brush,
    input  logic [2:0] color,
    output logic       hsync,
    output logic       vsync,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       busy
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned GRID_W  = H_ACTIVE >> CELL_LOG2;
    localparam int unsigned GRID_H  = V_ACTIVE >> CELL_LOG2;
    localparam int unsigned CELLS   = GRID_W * GRID_H;
    localparam int unsigned PD_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int unsigned MD_W    = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam int unsigned HC_W    = $clog2(H_TOTAL);
    localparam int unsigned VC_W    = $clog2(V_TOTAL);
    localparam int unsigned CX_W    = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam int unsigned CY_W    = (GRID_H > 1) ? $clog2(GRID_H) : 1;
    localparam int unsigned AW      = (CELLS > 1) ? $clog2(CELLS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_PAINT, S_CLEAR} state_t;

    logic [PD_W-1:0] pix_cnt;
    logic [MD_W-1:0] move_cnt;
    logic [HC_W-1:0] h_cnt;
    logic [VC_W-1:0] v_cnt;
    logic            pix_tick, move_tick;

    assign pix_tick  = (pix_cnt == PD_W'(PIX_DIV - 1));
    assign move_tick = (move_cnt == MD_W'(MOVE_DIV - 1));

    // Pixel/move dividers and raster counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            pix_cnt  <= '0;
            move_cnt <= '0;
            h_cnt    <= '0;
            v_cnt    <= '0;
        end else begin
            pix_cnt  <= pix_tick ? '0 : pix_cnt + PD_W'(1);
            move_cnt <= move_tick ? '0 : move_cnt + MD_W'(1);
            if (pix_tick) begin
                if (h_cnt == HC_W'(H_TOTAL - 1)) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == VC_W'(V_TOTAL - 1)) ? '0 : v_cnt + VC_W'(1);
                end else begin
                    h_cnt <= h_cnt + HC_W'(1);
                end
            end
        end
    end

    logic [2:0]      fb [CELLS];
    logic            fb_we;
    logic [AW-1:0]   fb_wa, rd_addr;
    logic [2:0]      fb_wd, rd_pix;
    logic [CX_W-1:0] sx, cx, cx_nx, p_x, px_nx;
    logic [CY_W-1:0] sy, cy, cy_nx, p_y, py_nx;
    logic            h_act, v_act, hs_on, vs_on;
    logic            x_near, y_near, cursor_px;

    assign h_act = (h_cnt < HC_W'(H_ACTIVE));
    assign v_act = (v_cnt < VC_W'(V_ACTIVE));
    assign hs_on = (h_cnt >= HC_W'(H_ACTIVE + H_FP)) && (h_cnt <= HC_W'(H_ACTIVE + H_FP + H_SYNC - 1));
    assign vs_on = (v_cnt >= VC_W'(V_ACTIVE + V_FP)) && (v_cnt <= VC_W'(V_ACTIVE + V_FP + V_SYNC - 1));
    assign sx    = CX_W'(h_cnt >> CELL_LOG2);
    assign sy    = CY_W'(v_cnt >> CELL_LOG2);

    assign rd_addr = (h_act && v_act) ? AW'(32'(sy) * GRID_W + 32'(sx)) : '0;
    assign rd_pix  = fb[rd_addr];

    // Cursor cross: adjacency is measured without wrap-around
    assign x_near = (sx == cx) || ({1'b0, sx} == {1'b0, cx} + (CX_W+1)'(1))
                               || ({1'b0, cx} == {1'b0, sx} + (CX_W+1)'(1));
    assign y_near = (sy == cy) || ({1'b0, sy} == {1'b0, cy} + (CY_W+1)'(1))
                               || ({1'b0, cy} == {1'b0, sy} + (CY_W+1)'(1));
    assign cursor_px = ((sx == cx) && y_near) || ((sy == cy) && x_near);

    always_ff @(posedge clk) begin
        if (!reset) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else begin
            hsync <= ~hs_on;
            vsync <= ~vs_on;
            if (h_act && v_act && !cursor_px) begin
                red   <= {4{rd_pix[0]}};
                green <= {4{rd_pix[1]}};
                blue  <= {4{rd_pix[2]}};
            end else begin
                red   <= '0;
                green <= '0;
                blue  <= '0;
            end
        end
    end

    // Reset must not let an in-flight operation write on the aborting edge
    always_ff @(posedge clk) begin
        if (reset && fb_we) fb[fb_wa] <= fb_wd;
    end

    state_t             state, state_nx;
    logic signed [2:0]  p_r, pr_nx, dx, dx_nx, dy, dy_nx;
    logic [2:0]         p_col, pc_nx;
    logic [AW-1:0]      clr_idx, clr_nx;
    logic               clear_q, clear_pend, pend_nx, clear_rise;
    logic signed [CX_W+1:0] tx;
    logic signed [CY_W+1:0] ty;
    logic               tx_ok, ty_ok;

    assign clear_rise = clear && !clear_q;
    assign tx    = $signed({2'b00, p_x}) + (CX_W+2)'(dx);
    assign ty    = $signed({2'b00, p_y}) + (CY_W+2)'(dy);
    assign tx_ok = !tx[CX_W+1] && (tx[CX_W:0] < (CX_W+1)'(GRID_W));
    assign ty_ok = !ty[CY_W+1] && (ty[CY_W:0] < (CY_W+1)'(GRID_H));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_CLEAR;
            cx         <= '0;
            cy         <= '0;
            p_x        <= '0;
            p_y        <= '0;
            p_r        <= '0;
            p_col      <= '0;
            dx         <= '0;
            dy         <= '0;
            clr_idx    <= '0;
            clear_q    <= 1'b0;
            clear_pend <= 1'b0;
            busy       <= 1'b1;
        end else begin
            state      <= state_nx;
            cx         <= cx_nx;
            cy         <= cy_nx;
            p_x        <= px_nx;
            p_y        <= py_nx;
            p_r        <= pr_nx;
            p_col      <= pc_nx;
            dx         <= dx_nx;
            dy         <= dy_nx;
            clr_idx    <= clr_nx;
            clear_q    <= clear;
            clear_pend <= pend_nx;
            busy       <= (state_nx != S_IDLE);
        end
    end

    always_comb begin
        state_nx = state;
        cx_nx    = cx;
        cy_nx    = cy;
        px_nx    = p_x;
        py_nx    = p_y;
        pr_nx    = p_r;
        pc_nx    = p_col;
        dx_nx    = dx;
        dy_nx    = dy;
        clr_nx   = clr_idx;
        pend_nx  = clear_pend;
        fb_we    = 1'b0;
        fb_wa    = '0;
        fb_wd    = BG_COLOR;
        unique case (state)
            S_IDLE: begin
                if (clear_rise || clear_pend) begin
                    state_nx = S_CLEAR;
                    clr_nx   = '0;
                    pend_nx  = 1'b0;
                end else if (paint) begin
                    state_nx = S_PAINT;
                    px_nx    = cx;
                    py_nx    = cy;
                    pr_nx    = brush[1] ? 3'sd2 : $signed({2'b00, brush[0]});
                    pc_nx    = color;
                    dx_nx    = -pr_nx;
                    dy_nx    = -pr_nx;
                end else if (move_tick) begin
                    if (left)       cx_nx = (cx == '0) ? CX_W'(GRID_W - 1) : cx - CX_W'(1);
                    else if (right) cx_nx = (cx == CX_W'(GRID_W - 1)) ? '0 : cx + CX_W'(1);
                    if (up)         cy_nx = (cy == '0) ? CY_W'(GRID_H - 1) : cy - CY_W'(1);
                    else if (down)  cy_nx = (cy == CY_W'(GRID_H - 1)) ? '0 : cy + CY_W'(1);
                end
            end
            S_PAINT: begin
                if (clear_rise) pend_nx = 1'b1;
                fb_we = tx_ok && ty_ok;
                fb_wa = AW'(32'(ty[CY_W-1:0]) * GRID_W + 32'(tx[CX_W-1:0]));
                fb_wd = p_col;
                if (dx == p_r) begin
                    dx_nx = -p_r;
                    if (dy == p_r) state_nx = S_IDLE;
                    else           dy_nx = dy + 3'sd1;
                end else begin
                    dx_nx = dx + 3'sd1;
                end
            end
            S_CLEAR: begin
                fb_we = 1'b1;
                fb_wa = clr_idx;
                if (clr_idx == AW'(CELLS - 1)) state_nx = S_IDLE;
                else                          clr_nx = clr_idx + AW'(1);
            end
            default: state_nx = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_paint_canvas_ctrl.sv
// Bench for paint_canvas_ctrl: random paint/move/clear traffic checked against a
// cell-array canvas model and a raster-position model of the scan output.
module tb_paint_canvas_ctrl;
    localparam int PD = 2;
    localparam int HA = 32, HF = 2, HS = 4, HB = 2;
    localparam int VA = 24, VF = 1, VS = 2, VB = 1;
    localparam int CL = 2;
    localparam int MD = 4;
    localparam logic [2:0] BG = 3'b110;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int GW = HA >> CL;
    localparam int GH = VA >> CL;
    localparam int NC = GW * GH;
    localparam logic [13:0] RST_OUT = 14'h3000;

    logic       clk = 1'b0, reset = 1'b0;
    logic       left = 0, right = 0, up = 0, down = 0, paint = 0, clear = 0;
    logic [1:0] brush = '0;
    logic [2:0] color = '0;
    logic       hsync, vsync, busy;
    logic [3:0] red, green, blue;

    paint_canvas_ctrl #(
        .PIX_DIV(PD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CELL_LOG2(CL), .MOVE_DIV(MD), .BG_COLOR(BG)
    ) dut (
        .clk(clk), .reset(reset), .left(left), .right(right), .up(up), .down(down),
        .paint(paint), .clear(clear), .brush(brush), .color(color),
        .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int since_rst = 0;
    logic [2:0] cv [NC];
    int mcx, mcy;

    always @(posedge clk) since_rst <= reset ? since_rst + 1 : 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [13:0] exp_px(input int k);
        int p, h, v, sx, sy;
        logic hs, vs;
        logic [2:0] c;
        if (k < 1) return RST_OUT;
        p  = ((k - 1) / PD) % (HT * VT);
        h  = p % HT;
        v  = p / HT;
        hs = !(h >= HA + HF && h < HA + HF + HS);
        vs = !(v >= VA + VF && v < VA + VF + VS);
        c  = 3'b000;
        if (h < HA && v < VA) begin
            sx = h >> CL;
            sy = v >> CL;
            if (!((sx == mcx && (sy - mcy) * (sy - mcy) <= 1) ||
                  (sy == mcy && (sx - mcx) * (sx - mcx) <= 1)))
                c = cv[sy * GW + sx];
        end
        return {hs, vs, {4{c[0]}}, {4{c[1]}}, {4{c[2]}}};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NC; i++) cv[i] = BG;
        mcx = 0;
        mcy = 0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 500) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic count_idle(output int n);
        n = 0;
        while (busy !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic expect_busy(input string tag, input int exp);
        int n;
        count_busy(n);
        check_eq(tag, n, exp);
    endtask

    task automatic frame_check(input string tag);
        @(negedge clk);
        repeat (HT * VT * PD) begin
            @(negedge clk);
            check_eq(tag, {hsync, vsync, red, green, blue}, exp_px(since_rst));
        end
    endtask

    task automatic move(input logic l, input logic r, input logic u, input logic d);
        left = l; right = r; up = u; down = d;
        repeat (MD) @(negedge clk);
        left = 0; right = 0; up = 0; down = 0;
        if (l)      mcx = (mcx + GW - 1) % GW;
        else if (r) mcx = (mcx + 1) % GW;
        if (u)      mcy = (mcy + GH - 1) % GH;
        else if (d) mcy = (mcy + 1) % GH;
    endtask

    task automatic model_paint(input int br, input logic [2:0] col);
        int r, x, y;
        r = (br >= 2) ? 2 : br;
        for (int dy = -r; dy <= r; dy++)
            for (int dx = -r; dx <= r; dx++) begin
                x = mcx + dx;
                y = mcy + dy;
                if (x >= 0 && x < GW && y >= 0 && y < GH) cv[y * GW + x] = col;
            end
    endtask

    task automatic do_paint(input int br, input logic [2:0] col);
        int r;
        r = (br >= 2) ? 2 : br;
        brush = 2'(br);
        color = col;
        paint = 1;
        @(negedge clk);
        paint = 0;
        brush = 2'($urandom_range(0, 3));
        color = 3'($urandom_range(0, 7));
        model_paint(br, col);
        expect_busy("paint_busy", (2 * r + 1) * (2 * r + 1));
    endtask

    task automatic do_clear();
        clear = 1;
        @(negedge clk);
        clear = 0;
        for (int i = 0; i < NC; i++) cv[i] = BG;
        expect_busy("clear_busy", NC);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, op;
        repeat (3) @(negedge clk);
        check_eq("rst_out", {hsync, vsync, red, green, blue}, RST_OUT);
        reset = 1;
        model_reset();
        expect_busy("rst_busy", NC);
        frame_check("scan_bg");

        // Wrap-around moves and left-over-right priority
        move(1, 0, 0, 0);
        check_eq("wrap_cx", mcx, GW - 1);
        move(0, 0, 1, 0);
        move(1, 1, 0, 0);
        frame_check("scan_moves");

        // Walk to (4,3) and paint a red 3x3, then step off to reveal the centre
        while (mcx != 4) move(1, 0, 0, 0);
        while (mcy != 3) move(0, 0, 1, 0);
        do_paint(1, 3'b001);
        move(0, 1, 0, 1);
        move(0, 1, 0, 1);
        frame_check("scan_red");

        // Corner 5x5 brush is clipped, not wrapped
        while (mcx != 0) move(1, 0, 0, 0);
        while (mcy != 0) move(0, 0, 1, 0);
        do_paint(2, 3'b010);
        frame_check("scan_corner");

        // Paint held high re-enters after a single idle cycle
        move(0, 1, 0, 1);
        move(0, 1, 0, 1);
        move(0, 1, 0, 1);
        brush = 2'd0;
        color = 3'b100;
        paint = 1;
        @(negedge clk);
        count_busy(n);
        check_eq("reenter_busy1", n, 1);
        count_idle(n);
        check_eq("reenter_gap", n, 1);
        paint = 0;
        count_busy(n);
        check_eq("reenter_busy2", n, 1);
        model_paint(0, 3'b100);
        frame_check("scan_reenter");

        // Clear edge during the third paint cycle is deferred until paint completes
        brush = 2'd1;
        color = 3'b011;
        paint = 1;
        @(negedge clk);
        paint = 0;
        repeat (2) @(negedge clk);
        clear = 1;
        @(negedge clk);
        clear = 0;
        count_busy(n);
        check_eq("paint_before_clr", n, 6);
        count_idle(n);
        check_eq("clr_gap", n, 1);
        count_busy(n);
        check_eq("deferred_clr", n, NC);
        for (int i = 0; i < NC; i++) cv[i] = BG;
        frame_check("scan_clr");

        // Reset in the middle of a clear aborts it and restarts a full clear
        do_paint(2, 3'b001);
        move(0, 1, 0, 1);
        clear = 1;
        @(negedge clk);
        clear = 0;
        repeat (20) @(negedge clk);
        reset = 0;
        repeat (2) @(negedge clk);
        check_eq("midclr_rst_out", {hsync, vsync, red, green, blue}, RST_OUT);
        reset = 1;
        model_reset();
        expect_busy("midclr_rst_busy", NC);
        frame_check("scan_after_rst");

        for (int it = 0; it < 16; it++) begin
            op = $urandom_range(0, 9);
            if (op == 0) begin
                do_clear();
            end else if (op <= 4) begin
                do_paint($urandom_range(0, 3), 3'($urandom_range(0, 7)));
            end else begin
                repeat ($urandom_range(1, 4))
                    move(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            frame_check("scan_rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
